fpga_ser_gearbox: RTL and testbench

- Parametrised, technology-independent parallel-to-serial gearbox on a single clock.
- Each parallel word of DATA_W bits per lane is emitted as R = DATA_W/OUT_W consecutive OUT_W-bit slices per lane.
- Typical use: feeding DDR output flops (OUT_W=2) or narrower SERDES primitives, for multi-lane video/CSI/HDMI transmit paths.
- Adds what the fixed 10:1 primitive wrapper lacks: generic widths, lane count, valid/ready back-pressure, idle-word insertion, bit-order select, word-alignment marker and underrun reporting.

---
 rtl/fpga_ser_gearbox.sv | 108 ++++++++++
 tb/tb_fpga_ser_gearbox.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fpga_ser_gearbox.sv
// Parallel-to-serial gearbox: each DATA_W-bit word per lane leaves as DATA_W/OUT_W slices,
// with a one-word holding register, idle-word insertion, alignment marker and underrun pulse.
`timescale 1ns/1ps
module fpga_ser_gearbox #(
  parameter int              DATA_W    = 10,
  parameter int              OUT_W     = 2,
  parameter int              LANES     = 1,
  parameter bit              LSB_FIRST = 1'b1,
  parameter logic [DATA_W-1:0] IDLE_WORD = {DATA_W{1'b0}}
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     en,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*DATA_W-1:0]  in_data,
  output logic [LANES*OUT_W-1:0]   out_data,
  output logic                     out_first,
  output logic                     out_idle,
  output logic                     underrun
);

  localparam int R  = DATA_W / OUT_W;
  localparam int CW = (R > 1) ? $clog2(R) : 1;
  localparam logic [CW-1:0] LAST = CW'(R - 1);
  localparam logic [LANES*DATA_W-1:0] IDLE_ALL = {LANES{IDLE_WORD}};

  logic [LANES*DATA_W-1:0] sh_reg;
  logic [LANES*DATA_W-1:0] hold_reg;
  logic [CW-1:0]           cnt_reg;
  logic                    hold_vld_reg;
  logic                    seen_reg;
  logic                    idle_reg;
  logic                    underrun_reg;
  logic                    ld;
  logic                    accept;

  assign ld       = (cnt_reg == LAST);
  // Gated by arst_n so the block never advertises space while held in reset.
  assign in_ready = arst_n & en & (~hold_vld_reg | ld);
  assign accept   = in_valid & in_ready;

  assign out_first = (cnt_reg == '0);
  assign out_idle  = idle_reg;
  assign underrun  = underrun_reg;

  // Slot decode: slices are pre-split at fixed offsets, then selected by the slot counter.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [OUT_W-1:0] slc [R];
      for (genvar gj = 0; gj < R; gj++) begin : g_slot
        if (LSB_FIRST) begin : g_lsb
          assign slc[gj] = sh_reg[gi*DATA_W + gj*OUT_W +: OUT_W];
        end else begin : g_msb
          assign slc[gj] = sh_reg[gi*DATA_W + DATA_W - 1 - gj*OUT_W -: OUT_W];
        end
      end
      assign out_data[gi*OUT_W +: OUT_W] = slc[cnt_reg];
    end
  endgenerate

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sh_reg       <= IDLE_ALL;
      hold_reg     <= '0;
      cnt_reg      <= '0;
      hold_vld_reg <= 1'b0;
      seen_reg     <= 1'b0;
      idle_reg     <= 1'b1;
      underrun_reg <= 1'b0;
    end else if (!en) begin
      // Disable realigns to slot 0 of an idle word and drops any held word.
      sh_reg       <= IDLE_ALL;
      cnt_reg      <= '0;
      hold_vld_reg <= 1'b0;
      seen_reg     <= 1'b0;
      idle_reg     <= 1'b1;
      underrun_reg <= 1'b0;
    end else begin
      underrun_reg <= 1'b0;
      cnt_reg      <= ld ? '0 : cnt_reg + 1'b1;
      if (accept) begin
        seen_reg <= 1'b1;
      end
      if (ld) begin
        if (hold_vld_reg) begin
          sh_reg       <= hold_reg;
          idle_reg     <= 1'b0;
          hold_vld_reg <= accept;
          if (accept) begin
            hold_reg <= in_data;
          end
        end else if (accept) begin
          sh_reg   <= in_data;
          idle_reg <= 1'b0;
        end else begin
          sh_reg       <= IDLE_ALL;
          idle_reg     <= 1'b1;
          underrun_reg <= seen_reg;
        end
      end else if (accept) begin
        hold_reg     <= in_data;
        hold_vld_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fpga_ser_gearbox.sv
// Bench for fpga_ser_gearbox: two-lane LSB-first and MSB-first instances share stimulus and
// are checked each cycle against a word-queue model plus hand-computed slice literals.
`timescale 1ns/1ps
module tb_fpga_ser_gearbox;
  localparam int R = 5;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        en = 1'b0;
  logic        in_valid = 1'b0;
  logic [19:0] in_data = '0;
  logic        rdy_a, rdy_b, first_a, first_b, idle_a, idle_b, und_a, und_b;
  logic [3:0]  out_a, out_b;

  int total = 0;
  int bad = 0;
  int lit_a = -1;
  int lit_b = -1;
  int lit_u = -1;

  // Model: current word, its slot position, words waiting to start, and the seen flag.
  int          m_pos = 0;
  logic [19:0] m_cur = '0;
  bit          m_idle = 1'b1;
  bit          m_seen = 1'b0;
  bit          m_und = 1'b0;
  logic [19:0] m_q[$];

  always #5 clk = ~clk;

  fpga_ser_gearbox #(.DATA_W(10), .OUT_W(2), .LANES(2), .LSB_FIRST(1'b1), .IDLE_WORD(10'h000)) dut_a (
    .clk(clk), .arst_n(arst_n), .en(en), .in_valid(in_valid), .in_ready(rdy_a), .in_data(in_data),
    .out_data(out_a), .out_first(first_a), .out_idle(idle_a), .underrun(und_a));

  fpga_ser_gearbox #(.DATA_W(10), .OUT_W(2), .LANES(2), .LSB_FIRST(1'b0), .IDLE_WORD(10'h000)) dut_b (
    .clk(clk), .arst_n(arst_n), .en(en), .in_valid(in_valid), .in_ready(rdy_b), .in_data(in_data),
    .out_data(out_b), .out_first(first_b), .out_idle(idle_b), .underrun(und_b));

  function automatic logic [3:0] exp_out(input bit lsb);
    logic [3:0] r;
    logic [9:0] w;
    int sh;
    r = '0;
    for (int k = 0; k < 2; k++) begin
      w  = m_cur[k*10 +: 10];
      sh = lsb ? 2*m_pos : 10 - 2*(m_pos + 1);
      r[k*2 +: 2] = 2'(w >> sh);
    end
    return r;
  endfunction

  function automatic bit exp_ready();
    return arst_n && en && (m_q.size() == 0 || m_pos == R-1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model update on every active edge or reset assertion.
  initial begin
    bit acc;
    forever begin
      @(posedge clk or negedge arst_n);
      if (!arst_n || !en) begin
        m_pos = 0; m_cur = '0; m_idle = 1'b1; m_seen = 1'b0; m_und = 1'b0;
        m_q.delete();
      end else begin
        acc   = in_valid && exp_ready();
        m_und = 1'b0;
        if (m_pos == R-1) begin
          if (m_q.size() != 0) begin
            m_cur = m_q.pop_front(); m_idle = 1'b0;
            if (acc) m_q.push_back(in_data);
          end else if (acc) begin
            m_cur = in_data; m_idle = 1'b0;
          end else begin
            m_cur = '0; m_idle = 1'b1; m_und = m_seen;
          end
        end else if (acc) begin
          m_q.push_back(in_data);
        end
        if (acc) m_seen = 1'b1;
        m_pos = (m_pos + 1) % R;
      end
    end
  end

  // Single compare process, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("out_a", out_a, exp_out(1'b1));
      chk("out_b", out_b, exp_out(1'b0));
      chk("first_a", first_a, m_pos == 0);
      chk("first_b", first_b, m_pos == 0);
      chk("idle_a", idle_a, m_idle);
      chk("idle_b", idle_b, m_idle);
      chk("und_a", und_a, m_und);
      chk("und_b", und_b, m_und);
      chk("rdy_a", rdy_a, exp_ready());
      chk("rdy_b", rdy_b, exp_ready());
      if (lit_a >= 0) chk("lit_out_a", out_a, lit_a);
      if (lit_b >= 0) chk("lit_out_b", out_b, lit_b);
      if (lit_u >= 0) chk("lit_und", und_a, lit_u);
    end
  end

  // One cycle: drive inputs and state the literal outputs expected during this cycle.
  task automatic step(input bit e, input bit v, input logic [19:0] d,
                      input int ea, input int eb, input int eu);
    en = e; in_valid = v; in_data = d;
    lit_a = ea; lit_b = eb; lit_u = eu;
    @(posedge clk); #1;
  endtask

  function automatic logic [19:0] dw(input logic [9:0] w);
    return {w, w};
  endfunction

  // Expected slices of a duplicated word with 2 lanes: {s,s} = s*5.
  int s_3a5_l[5] = '{5, 5, 10, 10, 15};
  int s_3a5_m[5] = '{15, 10, 10, 5, 5};
  int s_0f0_l[5] = '{0, 0, 15, 15, 0};
  int s_0f0_m[5] = '{0, 15, 15, 0, 0};
  int s_1e4_l[5] = '{0, 5, 10, 15, 5};
  int s_1e4_m[5] = '{5, 15, 10, 5, 0};

  initial begin
    repeat (3) begin @(posedge clk); #1; end
    arst_n = 1'b1;

    // Idle stream after reset: all zero, no underrun.
    for (int i = 0; i < 12; i++) step(1, 0, '0, 0, 0, 0);
    step(0, 0, '0, -1, -1, -1);

    // Two-word stream with in_valid held high.
    step(1, 1, dw(10'h3A5), 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, dw(10'h0F0), 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, '0, s_3a5_l[i], s_3a5_m[i], 0);
    for (int i = 0; i < 5; i++) step(1, 0, '0, s_0f0_l[i], s_0f0_m[i], 0);
    step(1, 0, '0, 0, 0, 1);
    step(1, 0, '0, 0, 0, 0);
    step(0, 0, '0, -1, -1, -1);

    // Single word then starvation: underrun at each inserted idle word.
    step(1, 1, dw(10'h155), 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, '0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, '0, 5, 5, 0);
    step(1, 0, '0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 0, '0, 0, 0, 0);
    step(1, 0, '0, 0, 0, 1);
    step(1, 0, '0, 0, 0, 0);
    step(0, 0, '0, -1, -1, -1);

    // Two lanes carrying different words.
    step(1, 1, {10'h3FF, 10'h000}, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, '0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, '0, 12, 12, 0);
    step(1, 0, '0, 0, 0, 1);
    step(0, 0, '0, -1, -1, -1);

    // en dropped at slot 2 with a word held: that word must never appear.
    step(1, 1, dw(10'h2CB), 0, 0, 0);
    step(1, 0, '0, 0, 0, 0);
    step(0, 0, '0, 0, 0, 0);
    step(1, 1, dw(10'h1E4), 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, '0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, '0, s_1e4_l[i], s_1e4_m[i], 0);

    // Reset mid-word, with a second word held.
    in_valid = 1'b1; in_data = dw(10'h0F0);
    arst_n = 1'b0;
    step(1, 1, dw(10'h0F0), 0, 0, 0);
    step(1, 1, dw(10'h0F0), 0, 0, 0);
    arst_n = 1'b1;
    step(1, 1, dw(10'h1E4), 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, '0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, '0, s_1e4_l[i], s_1e4_m[i], 0);
    step(1, 0, '0, 0, 0, 1);
    step(1, 0, '0, -1, -1, -1);

    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
